// File: rtl/contador_param.sv
// Parameterised LED counter: prescaled step rate, up/down/ping-pong/hold modes,
// clamped synchronous load, async-assert / sync-release reset.
module contador_param #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 4,
  parameter int MODULO  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             tick,
  output logic             wrap,
  output logic             dir
);

  localparam int DIV   = (TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 0;
  localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'((DIV > 0) ? DIV - 1 : 0);
  localparam logic [PSC_W-1:0] PSC_ONE = PSC_W'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'((MODULO > 0) ? MODULO - 1 : 0);
  localparam logic [WIDTH-1:0] PP_LOW  = WIDTH'((MODULO > 1) ? MODULO - 2 : 0);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  localparam logic MODES_OK = (WIDTH >= 1) && (MODULO >= 1) &&
                              (longint'(MODULO) <= (longint'(1) << WIDTH));

  if ((DIV < 1) || !MODES_OK) begin : g_param_check
    $fatal(1, "contador_param: illegal parameters (need DIV>=1, WIDTH>=1, 1<=MODULO<=2**WIDTH)");
  end

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

  logic [1:0]       rst_sync_reg;
  logic             run_ok;
  logic [PSC_W-1:0] psc_reg;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             dir_reg, dir_next;
  logic             wrap_next;
  logic             tick_reg, wrap_reg;
  logic             step;
  logic [WIDTH-1:0] load_clamped;

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= '0;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign run_ok       = rst_sync_reg[1];
  assign step         = (psc_reg == PSC_MAX);
  assign load_clamped = (load_val > CNT_MAX) ? CNT_MAX : load_val;

  always_comb begin
    count_next = count_reg;
    dir_next   = dir_reg;
    wrap_next  = 1'b0;
    case (mode)
      MODE_UP: begin
        if (count_reg == CNT_MAX) begin
          count_next = '0;
          wrap_next  = (MODULO > 1);
        end else begin
          count_next = count_reg + ONE;
        end
      end
      MODE_DOWN: begin
        if (count_reg == '0) begin
          count_next = CNT_MAX;
          wrap_next  = (MODULO > 1);
        end else begin
          count_next = count_reg - ONE;
        end
      end
      MODE_PP: begin
        // A single-value range has nowhere to bounce to: stay put, no reversal.
        if (MODULO == 1) begin
          count_next = '0;
        end else if (count_reg == CNT_MAX) begin
          count_next = PP_LOW;
          dir_next   = 1'b0;
          wrap_next  = 1'b1;
        end else if (count_reg == '0) begin
          count_next = ONE;
          dir_next   = 1'b1;
          wrap_next  = 1'b1;
        end else begin
          count_next = dir_reg ? count_reg + ONE : count_reg - ONE;
        end
      end
      default: begin
        count_next = count_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_reg   <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b1;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else if (!run_ok) begin
      psc_reg   <= '0;
      count_reg <= '0;
      dir_reg   <= 1'b1;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else if (load) begin
      psc_reg   <= '0;
      count_reg <= load_clamped;
      tick_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
    end else if (en) begin
      psc_reg  <= step ? '0 : psc_reg + PSC_ONE;
      tick_reg <= step;
      if (step) begin
        count_reg <= count_next;
        dir_reg   <= dir_next;
        wrap_reg  <= wrap_next;
      end else begin
        wrap_reg  <= 1'b0;
      end
    end else begin
      tick_reg <= 1'b0;
      wrap_reg <= 1'b0;
    end
  end

  assign leds = count_reg;
  assign tick = tick_reg;
  assign wrap = wrap_reg;
  assign dir  = dir_reg;

endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000: input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1: count-step rate in Hz; prescaler divisor DIV = CLK_HZ/TICK_HZ (integer division).
REQ-003 Parameter WIDTH, default 4: counter and LED width in bits.
REQ-004 Parameter MODULO, default 16: count range is 0..MODULO-1.
REQ-005 clk  input  1  system clock, all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 en  input  1  run enable; when 0, prescaler and count hold.
REQ-008 mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
REQ-009 load  input  1  synchronous load strobe.
REQ-010 load_val  input  WIDTH  value to load.
REQ-011 leds  output  WIDTH  current count, registered.
REQ-012 tick  output  1  one-cycle pulse on each count step.
REQ-013 wrap  output  1  one-cycle pulse on wrap-around or ping-pong turnaround.
REQ-014 dir  output  1  ping-pong direction, 1 = up, 0 = down.

Function
REQ-015 The block SHALL elaborate only if DIV >= 1, 1 <= MODULO <= 2^WIDTH, and WIDTH >= 1; otherwise it SHALL fail at elaboration.
REQ-016 The prescaler SHALL be a register of width clog2(DIV) (minimum 1) counting 0..DIV-1 while en=1, returning to 0 after DIV-1.
REQ-017 A step event SHALL occur on each edge where en=1 and prescaler==DIV-1; at that edge leds SHALL take its next value and tick SHALL be registered high for exactly the following cycle.
REQ-018 With DIV=1, a step event SHALL occur on every enabled cycle and tick SHALL stay high continuously.
REQ-019 Mode up: next = count+1, or 0 when count==MODULO-1; wrap SHALL pulse on the step from MODULO-1 to 0.
REQ-020 Mode down: next = count-1, or MODULO-1 when count==0; wrap SHALL pulse on the step from 0 to MODULO-1.
REQ-021 Mode ping-pong: at count==MODULO-1, next = MODULO-2 and dir<=0; at count==0, next = 1 and dir<=1; otherwise step by dir; wrap SHALL pulse on each reversal step.
REQ-022 Mode hold: the prescaler SHALL run and tick SHALL pulse, but count, dir and wrap SHALL NOT change.
REQ-023 With MODULO=1, count SHALL remain 0 in every mode, wrap SHALL NOT pulse, and tick SHALL still pulse.
REQ-024 Load SHALL take priority over a step event and over en: leds <= min(load_val, MODULO-1); prescaler <= 0; tick and wrap SHALL stay low; dir is unchanged.
REQ-025 A mode change SHALL take effect at the next step event; dir SHALL be kept across mode changes.
REQ-026 While en=0 (and load=0), all state SHALL hold, and tick and wrap SHALL be low.
REQ-027 All arithmetic SHALL be done modulo MODULO; leds SHALL never exceed MODULO-1.

Reset
REQ-028 When rst_n=0, the block SHALL immediately, without waiting for clk, set leds=0, prescaler=0, tick=0, wrap=0, dir=1.
REQ-029 Reset SHALL override load and en; deassertion SHALL be synchronised with a 2-flop synchroniser, so counting resumes on the 2nd-3rd edge after release.
REQ-030 Reset asserted mid-step SHALL discard any pending step; no tick or wrap SHALL be emitted for it.

Verification (CLK_HZ=8, TICK_HZ=2 → DIV=4, WIDTH=4, MODULO=10 unless stated)
REQ-031 Reset released, en=1, mode=00 → tick every 4 cycles; leds 0,1,…,9,0; wrap exactly with the 9→0 step.
REQ-032 mode=01 from 0 → leds 9,8,…; wrap on the 0→9 step; ping-pong mode=10 → 0..9,8..0,1…, dir toggles at 9 and 0, wrap at each reversal.
REQ-033 load=1, load_val=13 during prescaler==3 → leds=9, no tick that cycle, next tick 4 cycles after load.
REQ-034 en=0 for 7 cycles mid-period → leds and prescaler frozen, tick low; resumes with remaining phase.
REQ-035 MODULO=1 and DIV=1 builds → leds stuck at 0, tick constantly high, wrap never high.
REQ-036 rst_n pulsed low asynchronously between edges at leds=7 → leds=0 immediately and dir=1; no stray tick or wrap after release.
